// File: rtl/accumulator_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_control_unit
// Brief    : Fetch/decode/execute sequencer for a 16-bit accumulator machine.
//            It is the only master of the synchronous memory and the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_control_unit #(
    parameter int          DATA_W     = 16,
    parameter int          PC_W       = 12,
    parameter int          MEM_ADDR_W = 16,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [3:0]            alu_opcode,
    output logic [DATA_W-1:0]     alu_op1,
    output logic [DATA_W-1:0]     alu_op2,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  busy,
    output logic                  halted,
    output logic                  instr_done,
    output logic [PC_W-1:0]       pc,
    output logic [DATA_W-1:0]     ac,
    output logic [DATA_W-1:0]     ir
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_F_LATCH = 4'd2,
        S_DECODE  = 4'd3,
        S_MEM_RD  = 4'd4,
        S_M_LATCH = 4'd5,
        S_EXEC    = 4'd6,
        S_STORE   = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    localparam logic [3:0] C_OP_HALT  = 4'h0;
    localparam logic [3:0] C_OP_LOAD  = 4'h1;
    localparam logic [3:0] C_OP_STORE = 4'h2;
    localparam logic [3:0] C_OP_JUMP  = 4'h3;
    localparam logic [3:0] C_OP_JUMPZ = 4'h4;
    localparam logic [3:0] C_OP_ADD   = 4'h5;
    localparam logic [3:0] C_OP_SUB   = 4'h6;
    localparam logic [3:0] C_OP_AND   = 4'h7;
    localparam logic [3:0] C_OP_OR    = 4'h8;
    localparam logic [3:0] C_OP_XOR   = 4'h9;
    localparam logic [3:0] C_OP_SHL   = 4'hA;
    localparam logic [3:0] C_OP_SHR   = 4'hB;
    localparam logic [3:0] C_OP_CMPGT = 4'hC;
    localparam logic [3:0] C_OP_CMPEQ = 4'hD;
    localparam logic [3:0] C_OP_LOADI = 4'hE;

    localparam logic [3:0] C_ALU_ADD   = 4'b0000;
    localparam logic [3:0] C_ALU_SUB   = 4'b0001;
    localparam logic [3:0] C_ALU_SHL   = 4'b0100;
    localparam logic [3:0] C_ALU_SHR   = 4'b0101;
    localparam logic [3:0] C_ALU_AND   = 4'b1000;
    localparam logic [3:0] C_ALU_OR    = 4'b1001;
    localparam logic [3:0] C_ALU_XOR   = 4'b1010;
    localparam logic [3:0] C_ALU_CMPGT = 4'b1110;
    localparam logic [3:0] C_ALU_CMPEQ = 4'b1111;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic              halt_entry_q, halt_entry_d;
    logic [3:0]        op;

    assign op = ir_q[DATA_W-1 -: 4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_W'(RESET_PC);
            mar_q        <= '0;
            mbr_q        <= '0;
            ir_q         <= '0;
            ac_q         <= '0;
            halt_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mar_q        <= mar_d;
            mbr_q        <= mbr_d;
            ir_q         <= ir_d;
            ac_q         <= ac_d;
            halt_entry_q <= halt_entry_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mar_d        = mar_q;
        mbr_d        = mbr_q;
        ir_d         = ir_q;
        ac_d         = ac_q;
        halt_entry_d = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        alu_opcode   = 4'b0000;
        instr_done   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_addr = MEM_ADDR_W'(pc_q);
                state_d  = S_F_LATCH;
            end
            S_F_LATCH: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + PC_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                mar_d = ir_q[PC_W-1:0];
                case (op)
                    C_OP_LOAD, C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR,
                    C_OP_XOR, C_OP_CMPGT, C_OP_CMPEQ: state_d = S_MEM_RD;
                    C_OP_STORE: state_d = S_STORE;
                    C_OP_HALT: begin
                        state_d      = S_HALT;
                        halt_entry_d = 1'b1;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_MEM_RD: begin
                mem_addr = MEM_ADDR_W'(mar_q);
                state_d  = S_M_LATCH;
            end
            S_M_LATCH: begin
                mbr_d   = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                instr_done = 1'b1;
                state_d    = S_FETCH;
                case (op)
                    C_OP_LOAD:  ac_d = mbr_q;
                    C_OP_JUMP:  pc_d = mar_q;
                    C_OP_JUMPZ: if (ac_q == '0) pc_d = mar_q;
                    C_OP_LOADI: ac_d = DATA_W'(ir_q[PC_W-1:0]);
                    C_OP_ADD:   begin alu_opcode = C_ALU_ADD;   ac_d = alu_result; end
                    C_OP_SUB:   begin alu_opcode = C_ALU_SUB;   ac_d = alu_result; end
                    C_OP_AND:   begin alu_opcode = C_ALU_AND;   ac_d = alu_result; end
                    C_OP_OR:    begin alu_opcode = C_ALU_OR;    ac_d = alu_result; end
                    C_OP_XOR:   begin alu_opcode = C_ALU_XOR;   ac_d = alu_result; end
                    C_OP_SHL:   begin alu_opcode = C_ALU_SHL;   ac_d = alu_result; end
                    C_OP_SHR:   begin alu_opcode = C_ALU_SHR;   ac_d = alu_result; end
                    C_OP_CMPGT: begin alu_opcode = C_ALU_CMPGT; ac_d = alu_result; end
                    C_OP_CMPEQ: begin alu_opcode = C_ALU_CMPEQ; ac_d = alu_result; end
                    default: ;
                endcase
            end
            S_STORE: begin
                mem_addr   = MEM_ADDR_W'(mar_q);
                mem_we     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                // The HALT instruction completes on its first cycle in this state only.
                instr_done = halt_entry_q;
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_wdata = ac_q;
    assign alu_op1   = ac_q;
    assign alu_op2   = mbr_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign pc        = pc_q;
    assign ac        = ac_q;
    assign ir        = ir_q;

endmodule
`default_nettype wire

// File: doc/accumulator_control_unit.md
Name: accumulator_control_unit

Overview:
- Fetch/decode/execute sequencer for the 16-bit accumulator datapath.
- Owns PC, MAR, MBR, IR and AC as internal registers.
- Drives the synchronous main memory (one-cycle registered read) and the 4-bit-opcode combinational ALU through external ports.
- Sits between the two as the single master of both.

Parameters:
- DATA_W, 16, datapath/instruction width
- PC_W, 12, program counter and operand address width
- MEM_ADDR_W, 16, memory address port width; PC/MAR are zero-extended onto it
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  leave IDLE/HALT and begin fetching at current PC
- mem_addr  out  MEM_ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data (= AC)
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid the cycle after address presented with mem_we=0
- alu_opcode  out  4  ALU operation select
- alu_op1  out  DATA_W  = AC
- alu_op2  out  DATA_W  = MBR
- alu_result  in  DATA_W  combinational ALU result
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- pc  out  PC_W  current PC
- ac  out  DATA_W  accumulator
- ir  out  DATA_W  current instruction

Behaviour:
- Instruction format: [15:12] op, [11:0] addr/imm.
- Opcodes:
  - 0 HALT; 1 LOAD (AC<=M[a]); 2 STORE (M[a]<=AC); 3 JUMP (PC<=a); 4 JUMPZ (PC<=a if AC==0)
  - 5 ADD; 6 SUB; 7 AND; 8 OR; 9 XOR: AC <= ALU(AC, M[a])
  - A SHL; B SHR: AC <= ALU(AC), no memory read
  - C CMPGT; D CMPEQ: AC <= 1/0 via ALU
  - E LOADI: AC <= zero-extended imm12
  - F NOP
- ALU opcode mapping (driven only in EXEC, 4'b0000 otherwise): ADD 0000, SUB 0001, SHL 0100, SHR 0101, AND 1000, OR 1001, XOR 1010, CMPGT 1110, CMPEQ 1111.
- States: IDLE, FETCH, F_LATCH, DECODE, MEM_RD, M_LATCH, EXEC, STORE, HALT.
- Transitions:
  - IDLE -start-> FETCH
  - FETCH: mem_addr=PC, mem_we=0 -> F_LATCH
  - F_LATCH: IR<=mem_rdata, PC<=PC+1 (mod 2^PC_W) -> DECODE
  - DECODE: MAR<=IR[11:0]
    - op 1,5-9,C,D -> MEM_RD
    - op 2 -> STORE
    - op 0 -> HALT
    - else -> EXEC
  - MEM_RD: mem_addr=MAR, mem_we=0 -> M_LATCH
  - M_LATCH: MBR<=mem_rdata -> EXEC
  - EXEC: AC/PC update per op, instr_done=1 -> FETCH
  - STORE: mem_addr=MAR, mem_wdata=AC, mem_we=1 for exactly this cycle, instr_done=1 -> FETCH
  - HALT: instr_done=1 on entry cycle only; stays until start=1 -> FETCH (PC already points past HALT)
- start is ignored while busy.
- Latency:
  - 4 cycles: STORE, JUMP, JUMPZ, SHL, SHR, LOADI, NOP
  - 6 cycles: LOAD, ALU-with-memory ops, CMPGT, CMPEQ
  - HALT entered 3 cycles after FETCH
- Widths: all AC arithmetic wraps mod 2^16 via the ALU; LOAD bypasses the ALU (AC<=MBR in EXEC).
- PC wraps 0xFFF -> 0x000 silently.
- JUMP/JUMPZ overwrite the incremented PC in EXEC.
- mem_addr is zero-extended PC/MAR; in states without a memory access it is 0 with mem_we=0.
- Reset (reset=0, any time, including mid-STORE):
  - immediately: state=IDLE, mem_we=0
  - PC=RESET_PC; AC=MBR=IR=MAR=0
  - busy=halted=instr_done=0, alu_opcode=0
  - Resumes only on start after reset deasserts.

Test Plan:
- Reset mid-STORE (reset low during STORE cycle) -> mem_we drops to 0 same cycle without a clock edge; pc=0, ac=0, state IDLE; no write recorded.
- Program M[0]=E005 (LOADI 5), M[1]=5010 (ADD 0x010), M[2]=2011 (STORE 0x011), M[3]=0000, M[0x010]=0x0007; pulse start -> M[0x011]=0x000C, ac=0x000C, halted=1, pc=4, total 4+6+4+3=17 cycles after start.
- M[0]=E000, M[1]=4005 (JUMPZ 5), M[5]=E0AB, M[6]=0000 -> ac=0x00AB, pc=7; repeat with M[0]=E001 -> falls through to M[2].
- SUB underflow: AC=0x0001, operand 0x0002 -> ac=0xFFFF; CMPEQ with equal operands -> ac=0x0001, alu_opcode=1111 in EXEC only.
- PC wrap: RESET_PC=0xFFF, M[0xFFF]=F000, M[0]=0000 -> after NOP pc=0x000, then halts with pc=0x001.
- Halt/resume: in HALT, start=1 -> FETCH next cycle at pc; start asserted while busy -> no effect on sequence or cycle count.
